// File: rtl/end_screen_pkg.sv
// Shared types and widths for the game-over banner sequencer.
package end_screen_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FREEZE,
        SLIDE,
        SHOW,
        WAIT_RELEASE,
        RESTART
    } end_state_t;

    localparam int COORD_W     = 11;
    localparam int FRAME_CNT_W = 8;

endpackage

// File: rtl/end_screen_ctrl_frame_counter.sv
// Frame-rate counter with synchronous clear; saturates or wraps at MAX.
module frame_counter #(
    parameter int W    = 8,
    parameter int MAX  = 1,
    parameter bit WRAP = 1'b0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         clr,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] MAX_V = W'(MAX);

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            count <= '0;
        end else if (en) begin
            if (count >= MAX_V)
                count <= WRAP ? '0 : MAX_V;
            else
                count <= count + W'(1);
        end
    end

endmodule

// File: rtl/end_screen_ctrl.sv
// End-of-game banner sequencer: freeze, slide-in, blink, restart handshake.
module end_screen_ctrl
    import end_screen_pkg::*;
#(
    parameter int FREEZE_FRAMES = 30,
    parameter int SLIDE_STEP    = 4,
    parameter int TARGET_X      = 304,
    parameter int TARGET_Y      = 224,
    parameter int BLINK_HALF    = 16,
    parameter int MIN_SHOW      = 120
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               startOfFrame,
    input  logic               gameOver,
    input  logic               playerWin,
    input  logic               restartKey,
    output logic               freezeGame,
    output logic               bannerEnable,
    output logic [COORD_W-1:0] bannerTopLeftX,
    output logic [COORD_W-1:0] bannerTopLeftY,
    output logic               winFlag,
    output logic               restartGame
);

    localparam logic [FRAME_CNT_W-1:0] FREEZE_LAST = FRAME_CNT_W'(FREEZE_FRAMES - 1);
    localparam logic [FRAME_CNT_W-1:0] SHOW_MIN    = FRAME_CNT_W'(MIN_SHOW);
    localparam logic [FRAME_CNT_W-1:0] BLINK_H     = FRAME_CNT_W'(BLINK_HALF);
    localparam logic [FRAME_CNT_W-1:0] BLINK_MAX   = FRAME_CNT_W'(2 * BLINK_HALF - 1);
    localparam logic [COORD_W:0]       STEP_W      = (COORD_W + 1)'(SLIDE_STEP);
    localparam logic [COORD_W:0]       TGT_Y_W     = (COORD_W + 1)'(TARGET_Y);

    end_state_t state_q, state_d;

    logic                   armed_q, armed_d;
    logic                   freeze_d, en_d, win_d, restart_d;
    logic [COORD_W-1:0]     y_d;
    logic [COORD_W:0]       y_sum;
    logic [FRAME_CNT_W-1:0] frame_cnt, blink_cnt, blink_nx;
    logic                   fc_en, fc_clr, bl_en, bl_clr;

    frame_counter #(
        .W    (FRAME_CNT_W),
        .MAX  (MIN_SHOW),
        .WRAP (1'b0)
    ) u_frame_cnt (
        .clk   (clk),
        .reset (reset),
        .en    (fc_en),
        .clr   (fc_clr),
        .count (frame_cnt)
    );

    frame_counter #(
        .W    (FRAME_CNT_W),
        .MAX  (2 * BLINK_HALF - 1),
        .WRAP (1'b1)
    ) u_blink_cnt (
        .clk   (clk),
        .reset (reset),
        .en    (bl_en),
        .clr   (bl_clr),
        .count (blink_cnt)
    );

    always_comb begin
        state_d   = state_q;
        armed_d   = armed_q;
        freeze_d  = freezeGame;
        en_d      = bannerEnable;
        y_d       = bannerTopLeftY;
        win_d     = winFlag;
        restart_d = 1'b0;
        fc_en     = 1'b0;
        fc_clr    = 1'b0;
        bl_en     = 1'b0;
        bl_clr    = (state_q != SHOW);
        // 12-bit sum so a large step near the target cannot wrap
        y_sum     = {1'b0, bannerTopLeftY} + STEP_W;
        blink_nx  = (blink_cnt >= BLINK_MAX) ? '0 : blink_cnt + FRAME_CNT_W'(1);

        unique case (state_q)
            IDLE: begin
                fc_clr = 1'b1;
                if (gameOver || playerWin) begin
                    state_d  = FREEZE;
                    win_d    = playerWin;
                    freeze_d = 1'b1;
                end
            end
            FREEZE: begin
                if (startOfFrame) begin
                    if (frame_cnt == FREEZE_LAST) begin
                        state_d = SLIDE;
                        y_d     = '0;
                        en_d    = 1'b1;
                        fc_clr  = 1'b1;
                    end else begin
                        fc_en = 1'b1;
                    end
                end
            end
            SLIDE: begin
                if (startOfFrame) begin
                    if (y_sum >= TGT_Y_W) begin
                        y_d     = COORD_W'(TARGET_Y);
                        state_d = SHOW;
                        fc_clr  = 1'b1;
                        armed_d = 1'b0;
                    end else begin
                        y_d = y_sum[COORD_W-1:0];
                    end
                end
            end
            SHOW: begin
                // a key held since before SHOW must be released once to arm
                if (!restartKey) armed_d = 1'b1;
                if (startOfFrame) begin
                    fc_en = 1'b1;
                    bl_en = 1'b1;
                    en_d  = (blink_nx < BLINK_H);
                end
                if (restartKey && armed_q && frame_cnt == SHOW_MIN) begin
                    state_d = WAIT_RELEASE;
                    en_d    = 1'b1;
                    fc_en   = 1'b0;
                    bl_en   = 1'b0;
                end
            end
            WAIT_RELEASE: begin
                en_d = 1'b1;
                if (!restartKey) state_d = RESTART;
            end
            RESTART: begin
                restart_d = 1'b1;
                en_d      = 1'b0;
                freeze_d  = 1'b0;
                y_d       = '0;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            armed_q        <= 1'b0;
            freezeGame     <= 1'b0;
            bannerEnable   <= 1'b0;
            bannerTopLeftX <= COORD_W'(TARGET_X);
            bannerTopLeftY <= '0;
            winFlag        <= 1'b0;
            restartGame    <= 1'b0;
        end else begin
            state_q        <= state_d;
            armed_q        <= armed_d;
            freezeGame     <= freeze_d;
            bannerEnable   <= en_d;
            bannerTopLeftX <= COORD_W'(TARGET_X);
            bannerTopLeftY <= y_d;
            winFlag        <= win_d;
            restartGame    <= restart_d;
        end
    end

endmodule

// File: tb/tb_end_screen_ctrl.sv
// Directed bench for end_screen_ctrl with shortened timing parameters.
module tb_end_screen_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        startOfFrame = 1'b0;
    logic        gameOver = 1'b0;
    logic        playerWin = 1'b0;
    logic        restartKey = 1'b0;
    logic        freezeGame, bannerEnable, winFlag, restartGame;
    logic [10:0] bannerTopLeftX, bannerTopLeftY;

    int tests = 0;
    int fails = 0;

    end_screen_ctrl #(
        .FREEZE_FRAMES (3),
        .SLIDE_STEP    (100),
        .TARGET_X      (304),
        .TARGET_Y      (224),
        .BLINK_HALF    (2),
        .MIN_SHOW      (5)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .startOfFrame   (startOfFrame),
        .gameOver       (gameOver),
        .playerWin      (playerWin),
        .restartKey     (restartKey),
        .freezeGame     (freezeGame),
        .bannerEnable   (bannerEnable),
        .bannerTopLeftX (bannerTopLeftX),
        .bannerTopLeftY (bannerTopLeftY),
        .winFlag        (winFlag),
        .restartGame    (restartGame)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // one-cycle frame pulse followed by one idle cycle
    task automatic frame();
        startOfFrame = 1'b1;
        step();
        startOfFrame = 1'b0;
        step();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        chk("rst_freeze", freezeGame, 0);
        chk("rst_en", bannerEnable, 0);
        chk("rst_x", bannerTopLeftX, 304);
        chk("rst_y", bannerTopLeftY, 0);
        chk("rst_win", winFlag, 0);
        chk("rst_restart", restartGame, 0);

        gameOver = 1'b1;
        step();
        gameOver = 1'b0;
        chk("go_freeze", freezeGame, 1);
        chk("go_win", winFlag, 0);
        chk("go_en", bannerEnable, 0);
        frame();
        frame();
        chk("frz2_en", bannerEnable, 0);
        frame();
        chk("frz3_en", bannerEnable, 1);
        chk("frz3_y", bannerTopLeftY, 0);

        frame();
        chk("slide_y1", bannerTopLeftY, 100);
        frame();
        chk("slide_y2", bannerTopLeftY, 200);
        frame();
        chk("slide_y3", bannerTopLeftY, 224);

        chk("show_en0", bannerEnable, 1);
        frame();
        chk("show_en1", bannerEnable, 1);
        restartKey = 1'b1;
        frame();
        chk("show_en2", bannerEnable, 0);
        chk("early_key_restart", restartGame, 0);
        restartKey = 1'b0;
        frame();
        chk("show_en3", bannerEnable, 0);
        frame();
        chk("show_en4", bannerEnable, 1);
        frame();
        chk("show_en5", bannerEnable, 1);
        chk("show_freeze", freezeGame, 1);

        restartKey = 1'b1;
        step();
        chk("wait_en", bannerEnable, 1);
        step();
        step();
        chk("wait_restart", restartGame, 0);
        restartKey = 1'b0;
        step();
        chk("rel1_restart", restartGame, 0);
        step();
        chk("rel2_restart", restartGame, 1);
        chk("rel2_freeze", freezeGame, 0);
        chk("rel2_en", bannerEnable, 0);
        chk("rel2_y", bannerTopLeftY, 0);
        step();
        chk("rel3_restart", restartGame, 0);

        restartKey = 1'b1;
        gameOver = 1'b1;
        step();
        gameOver = 1'b0;
        chk("held_freeze", freezeGame, 1);
        for (int i = 0; i < 11; i++) frame();
        chk("held_y", bannerTopLeftY, 224);
        step();
        step();
        chk("held_restart", restartGame, 0);
        restartKey = 1'b0;
        step();
        chk("held_rel1", restartGame, 0);
        step();
        chk("held_rel2", restartGame, 0);
        chk("held_rel2_freeze", freezeGame, 1);
        restartKey = 1'b1;
        step();
        restartKey = 1'b0;
        step();
        chk("rearm1_restart", restartGame, 0);
        step();
        chk("rearm2_restart", restartGame, 1);
        chk("rearm2_freeze", freezeGame, 0);

        step();
        gameOver = 1'b1;
        playerWin = 1'b1;
        step();
        gameOver = 1'b0;
        playerWin = 1'b0;
        chk("both_win", winFlag, 1);
        chk("both_freeze", freezeGame, 1);
        for (int i = 0; i < 4; i++) frame();
        chk("mid_slide_y", bannerTopLeftY, 100);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("midrst_y", bannerTopLeftY, 0);
        chk("midrst_en", bannerEnable, 0);
        chk("midrst_freeze", freezeGame, 0);
        chk("midrst_win", winFlag, 0);
        chk("midrst_restart", restartGame, 0);
        frame();
        step();
        chk("post_restart", restartGame, 0);
        chk("post_freeze", freezeGame, 0);
        chk("post_y", bannerTopLeftY, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
